// File: rtl/if_prefetch_pkg.sv
// rtl/if_prefetch_pkg.sv - shared constants and instruction-select helper for the fetch unit
package if_prefetch_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [7:0]  AR_SIZE          = 8'b0000_1111;

    // A wide beat carries two instructions; pc[2] picks the upper one.
    function automatic logic [31:0] inst_select(input logic [63:0] beat,
                                                input logic        hi_half,
                                                input logic        wide_bus);
        if (wide_bus && hi_half)
            return beat[63:32];
        return beat[31:0];
    endfunction

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// rtl/if_prefetch_sync_fifo.sv - synchronous FIFO with flush, count and full/empty flags
module if_prefetch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so depths that are not a power of two still work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - pipelined instruction fetch with prefetch queue and redirect flushing
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              XLEN            = 64,
    parameter int              BUS_W           = 64,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             br_valid,
    input  logic [XLEN-1:0]  br_pc,
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [XLEN-1:0]  ar_addr,
    output logic [7:0]       ar_size,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [BUS_W-1:0] r_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_inst
);

    localparam int QW  = XLEN + 32;
    localparam int QCW = $clog2(FIFO_DEPTH + 1);
    localparam int ICW = $clog2(MAX_OUTSTANDING + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 2);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] ar_addr_q;
    logic            ar_valid_q;
    logic            r_ready_q;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] issue_pc;
    logic            ar_hs;
    logic            r_hs;
    logic            ar_valid_next;
    logic            launch;
    logic [OW-1:0]   out_next;
    logic [QCW-1:0]  q_next;
    logic            q_push;
    logic            q_pop;
    logic [31:0]     rsp_inst;

    logic [QCW-1:0]  q_count;
    logic            q_full;
    logic            q_empty;
    logic [QW-1:0]   q_head;
    logic [XLEN-1:0] rsp_pc;
    logic [ICW-1:0]  if_count;
    logic            if_full;
    logic            if_empty;
    logic            unused_flags;

    always_comb begin
        redirect    = trap_valid || br_valid;
        target      = trap_valid ? trap_pc : br_pc;
        target[1:0] = 2'b00;
        issue_pc    = redirect ? target : fetch_pc;
        ar_hs       = ar_valid_q && ar_ready;
        r_hs        = r_valid && r_ready_q;
        rsp_inst    = inst_select(64'(r_data), rsp_pc[2], BUS_W == 64);
        q_push      = r_hs && !redirect && (drop_cnt == '0);
        q_pop       = !q_empty && out_ready && !redirect;
        out_next    = outstanding + OW'(ar_hs) - OW'(r_hs);
        q_next      = redirect ? '0 : q_count + QCW'(q_push) - QCW'(q_pop);
        // Credit counts queued entries plus accepted reads, so every response has a slot.
        ar_valid_next = (ar_valid_q && !ar_hs) ||
                        ((32'(q_next) + 32'(out_next)) < 32'(FIFO_DEPTH) &&
                         32'(out_next) < 32'(MAX_OUTSTANDING));
        launch      = ar_valid_next && (!ar_valid_q || ar_hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            ar_addr_q   <= '0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            r_ready_q   <= 1'b1;
            ar_valid_q  <= ar_valid_next;
            outstanding <= out_next;
            if (launch) begin
                ar_addr_q <= issue_pc;
                fetch_pc  <= issue_pc + XLEN'(4);
            end else if (redirect) begin
                fetch_pc  <= target;
            end
            // Everything accepted so far, plus a held request, now returns stale data.
            if (redirect)
                drop_cnt <= out_next + OW'(ar_valid_q && !ar_hs);
            else if (r_hs && drop_cnt != '0)
                drop_cnt <= drop_cnt - OW'(1);
        end
    end

    if_prefetch_sync_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (q_push),
        .push_data ({rsp_pc, rsp_inst}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    if_prefetch_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (ar_hs),
        .push_data (ar_addr_q),
        .pop       (r_hs),
        .pop_data  (rsp_pc),
        .count     (if_count),
        .full      (if_full),
        .empty     (if_empty)
    );

    assign unused_flags = ^{q_full, if_full, if_empty, if_count};

    assign ar_valid  = ar_valid_q;
    assign ar_addr   = ar_addr_q;
    assign ar_size   = AR_SIZE;
    assign r_ready   = r_ready_q;
    assign out_valid = !q_empty;
    assign out_pc    = out_valid ? q_head[QW-1:32] : '0;
    assign out_inst  = out_valid ? q_head[31:0] : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - scoreboard bench for if_prefetch with a 1-cycle memory model
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        br_valid = 1'b0;
    logic [63:0] br_pc = '0;
    logic        ar_valid;
    logic        ar_ready = 1'b1;
    logic [63:0] ar_addr;
    logic [7:0]  ar_size;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    always #5 clk = ~clk;

    if_prefetch #(
        .XLEN            (64),
        .BUS_W           (64),
        .RESET_PC        (64'h8000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trap_valid (trap_valid),
        .trap_pc    (trap_pc),
        .br_valid   (br_valid),
        .br_pc      (br_pc),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_size    (ar_size),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst)
    );

    typedef struct {
        logic [63:0] addr;
        logic        stale;
    } rsp_t;

    rsp_t        resp_q[$];
    logic [63:0] sb_pc[$];
    logic [31:0] sb_inst[$];
    logic [63:0] ar_log[$];
    logic [63:0] pop_pc_log[$];
    logic [31:0] pop_inst_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        mem_hold = 1'b0;
    logic        r_valid_raw = 1'b0;
    logic [63:0] r_data_raw = '0;
    logic        ar_acc = 1'b0;
    logic        r_acc = 1'b0;
    logic [63:0] ar_acc_addr = '0;
    logic        stale_next_ar = 1'b0;

    assign r_valid = r_valid_raw && !mem_hold;
    assign r_data  = r_data_raw;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] beat_at(input logic [63:0] a);
        return {word_at({a[63:3], 3'b100}), word_at({a[63:3], 3'b000})};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Negedge: note handshakes for the coming edge, apply redirect staleness, score outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                resp_q.delete();
                sb_pc.delete();
                sb_inst.delete();
                stale_next_ar = 1'b0;
                ar_acc = 1'b0;
                r_acc = 1'b0;
            end else begin
                ar_acc      = ar_valid && ar_ready;
                ar_acc_addr = ar_addr;
                r_acc       = r_valid && r_ready;
                if (trap_valid || br_valid) begin
                    foreach (resp_q[i]) resp_q[i].stale = 1'b1;
                    if (ar_valid) stale_next_ar = 1'b1;
                    sb_pc.delete();
                    sb_inst.delete();
                end else if (out_valid && out_ready) begin
                    pop_pc_log.push_back(out_pc);
                    pop_inst_log.push_back(out_inst);
                    if (sb_pc.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
                    end else begin
                        check("sb_out_pc", out_pc, sb_pc.pop_front());
                        check("sb_out_inst", {32'h0, out_inst}, {32'h0, sb_inst.pop_front()});
                    end
                end
                if (r_acc && resp_q.size() > 0 && !resp_q[0].stale) begin
                    sb_pc.push_back(resp_q[0].addr);
                    sb_inst.push_back(word_at(resp_q[0].addr));
                end
            end
        end
    end

    // Memory: response beat is presented the cycle after the address is accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (r_acc && resp_q.size() > 0) void'(resp_q.pop_front());
            if (ar_acc) begin
                resp_q.push_back('{addr: ar_acc_addr, stale: stale_next_ar});
                ar_log.push_back(ar_acc_addr);
                stale_next_ar = 1'b0;
            end
            r_acc  = 1'b0;
            ar_acc = 1'b0;
            r_valid_raw = (resp_q.size() > 0);
            r_data_raw  = (resp_q.size() > 0) ? beat_at(resp_q[0].addr) : '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input string name);
        int k = 0;
        while (pop_pc_log.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (pop_pc_log.size() < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0d outputs required %0d", name, pop_pc_log.size(), n);
        end
    endtask

    task automatic wait_ars(input int n, input string name);
        int k = 0;
        while (ar_log.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (ar_log.size() < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0d requests required %0d", name, ar_log.size(), n);
        end
    endtask

    task automatic wait_resp(input int n, input string name);
        int k = 0;
        while (resp_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(resp_q.size() >= n), 64'd1);
    endtask

    task automatic check_pop(input int idx, input logic [63:0] pc, input string name);
        if (pop_pc_log.size() > idx) begin
            check({name, "_pc"}, pop_pc_log[idx], pc);
            check({name, "_inst"}, {32'h0, pop_inst_log[idx]}, {32'h0, word_at(pc)});
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no output at index %0d required pc %h", name, idx, pc);
        end
    endtask

    task automatic check_ar(input int idx, input logic [63:0] addr, input string name);
        if (ar_log.size() > idx) begin
            check(name, ar_log[idx], addr);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no request at index %0d required %h", name, idx, addr);
        end
    endtask

    int a0, p0, k;

    initial begin
        repeat (3) step();
        @(negedge clk);
        check("rst_ar_valid", {63'h0, ar_valid}, 64'd0);
        check("rst_r_ready", {63'h0, r_ready}, 64'd0);
        check("rst_out_valid", {63'h0, out_valid}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", {32'h0, out_inst}, 64'd0);
        check("ar_size", {56'h0, ar_size}, 64'h0F);

        // Free-running fetch: low/high/low halves of consecutive beats.
        step();
        p0 = pop_pc_log.size();
        rst = 1'b0;
        wait_pops(p0 + 3, "a_stream");
        check_pop(p0,     64'h8000_0000, "a0");
        check_pop(p0 + 1, 64'h8000_0004, "a1");
        check_pop(p0 + 2, 64'h8000_0008, "a2");
        check("a0_inst_hand", {32'h0, pop_inst_log[p0]}, 64'h9357_9BDF);
        check("a1_inst_hand", {32'h0, pop_inst_log[p0 + 1]}, 64'h9357_9BDB);

        // Decode stalled: queue fills to exactly four, then fetch stops.
        step();
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        a0 = ar_log.size();
        p0 = pop_pc_log.size();
        repeat (30) step();
        @(negedge clk);
        check("b_queued", 64'(sb_pc.size()), 64'd4);
        check("b_requests", 64'(ar_log.size() - a0), 64'd4);
        check("b_ar_idle", {63'h0, ar_valid}, 64'd0);
        check("b_out_valid", {63'h0, out_valid}, 64'd1);
        check("b_head_pc", out_pc, 64'h8000_0000);
        step();
        out_ready = 1'b1;
        wait_ars(a0 + 5, "b_resume");
        check_ar(a0 + 4, 64'h8000_0010, "b_resume_addr");
        wait_pops(p0 + 4, "b_drain");
        check_pop(p0,     64'h8000_0000, "b0");
        check_pop(p0 + 1, 64'h8000_0004, "b1");
        check_pop(p0 + 2, 64'h8000_0008, "b2");
        check_pop(p0 + 3, 64'h8000_000C, "b3");

        // Branch with two reads in flight: both beats must be dropped.
        step();
        mem_hold = 1'b1;
        wait_resp(2, "c_two_inflight");
        step();
        br_valid = 1'b1;
        br_pc = 64'h8000_1002;
        p0 = pop_pc_log.size();
        step();
        br_valid = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        check("c_flushed", {63'h0, out_valid}, 64'd0);
        wait_pops(p0 + 1, "c_target");
        check_pop(p0, 64'h8000_1000, "c_first");

        // Trap and branch together while a request is held by ar_ready=0.
        step();
        ar_ready = 1'b0;
        k = 0;
        while (!(resp_q.size() == 0 && ar_valid && sb_pc.size() == 0 && !out_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("d_quiet", 64'(k < 100), 64'd1);
        step();
        trap_valid = 1'b1;
        trap_pc = 64'h8000_0100;
        br_valid = 1'b1;
        br_pc = 64'h8000_2000;
        a0 = ar_log.size();
        p0 = pop_pc_log.size();
        step();
        trap_valid = 1'b0;
        br_valid = 1'b0;
        ar_ready = 1'b1;
        @(negedge clk);
        check("d_flushed", {63'h0, out_valid}, 64'd0);
        wait_ars(a0 + 2, "d_requests");
        check_ar(a0 + 1, 64'h8000_0100, "d_trap_addr");
        wait_pops(p0 + 1, "d_target");
        check_pop(p0, 64'h8000_0100, "d_first");

        // Response handshake in the same cycle as a redirect.
        step();
        mem_hold = 1'b1;
        wait_resp(2, "e_two_inflight");
        step();
        mem_hold = 1'b0;
        br_valid = 1'b1;
        br_pc = 64'h8000_3000;
        p0 = pop_pc_log.size();
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("e_no_spurious", {63'h0, out_valid}, 64'd0);
        wait_pops(p0 + 1, "e_target");
        check_pop(p0, 64'h8000_3000, "e_first");

        // Reset mid-stream with two reads outstanding.
        step();
        mem_hold = 1'b1;
        wait_resp(2, "f_two_inflight");
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("f_ar_valid", {63'h0, ar_valid}, 64'd0);
        check("f_r_ready", {63'h0, r_ready}, 64'd0);
        check("f_out_valid", {63'h0, out_valid}, 64'd0);
        check("f_out_pc", out_pc, 64'd0);
        check("f_out_inst", {32'h0, out_inst}, 64'd0);
        step();
        rst = 1'b0;
        mem_hold = 1'b0;
        a0 = ar_log.size();
        p0 = pop_pc_log.size();
        wait_ars(a0 + 1, "f_restart");
        check_ar(a0, 64'h8000_0000, "f_restart_addr");
        wait_pops(p0 + 1, "f_first");
        check_pop(p0, 64'h8000_0000, "f_first");

        step();
        ar_ready = 1'b0;
        k = 0;
        while (!(resp_q.size() == 0 && sb_pc.size() == 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("sb_drained", 64'(sb_pc.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Next-generation instruction fetch unit with a parametrised prefetch queue.
- Issues up to MAX_OUTSTANDING in-order read requests on the instruction read channel (valid/ready address, valid/ready data).
- Extracts the 32-bit instruction from a BUS_W-wide beat and buffers (pc, inst) pairs in a FIFO_DEPTH queue for decode.
- Trap/branch redirects flush the queue and silently discard every in-flight stale response. Replaces the single-request, address-compare fetch scheme.

Parameters:
- XLEN, 64, address/pc width.
- BUS_W, 64, read-data beat width; 32 or 64.
- RESET_PC, 64'h80000000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch queue entries; power of 2, >=2.
- MAX_OUTSTANDING, 2, in-flight read requests; 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trap_valid  in  1  trap redirect (mtvec); highest priority
- trap_pc  in  XLEN  trap target
- br_valid  in  1  jal/jalr/taken-branch redirect
- br_pc  in  XLEN  branch target
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address accepted
- ar_addr  out  XLEN  fetch address
- ar_size  out  8  byte mask, constant 8'b00001111
- r_valid  in  1  read data valid
- r_ready  out  1  read data ready
- r_data  in  BUS_W  read beat
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts instruction
- out_pc  out  XLEN  pc of out_inst
- out_inst  out  32  instruction

Behaviour:
- Reset values: fetch_pc=RESET_PC, ar_valid=0, r_ready=0, out_valid=0, out_pc=0, out_inst=0, queue empty, outstanding=0, drop_cnt=0. rst overrides all inputs, including redirects and responses in flight.
- r_ready=1 every cycle after reset. Queue credit guarantees space, so there is no data backpressure.
- Issue condition: (queue_count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING. First ar_valid is asserted the cycle after rst falls.
- Address hold: once ar_valid=1, it stays high with ar_addr stable until ar_ready. A redirect never retracts it; that request becomes stale.
- On ar handshake: fetch_pc += 4; outstanding++; ar_addr is pushed into the in-flight pc FIFO.
- On r handshake: outstanding--; the in-flight pc FIFO is popped.
  - drop_cnt>0: decrement drop_cnt, discard the beat.
  - Otherwise push (pc, inst) into the queue.
- Instruction select: BUS_W=64 gives inst = pc[2] ? r_data[63:32] : r_data[31:0]. BUS_W=32 gives inst = r_data.
- Latency: r handshake to out_valid=1 is 1 cycle. Queue pop occurs when out_valid && out_ready. Simultaneous push and pop is allowed at any count.
- Redirect (trap_valid || br_valid):
  - Target is trap_pc if trap_valid, else br_pc; bits [1:0] forced to 0.
  - fetch_pc <= target; queue flushed, so out_valid=0 next cycle and any same-cycle pop is ignored.
  - drop_cnt <= outstanding_after_this_cycle + (ar_valid && !ar_handshake ? 1 : 0). A response arriving in the redirect cycle is discarded.
- Redirect during drop: drop_cnt is recomputed per the rule above (not accumulated past in-flight total).
- Invariants: outstanding <= MAX_OUTSTANDING; queue never overflows; drop_cnt <= outstanding + 1.

Decomposition:
- Shared package holds RESET_PC default, the ar_size constant 8'b00001111, and the inst-select helper function.
- One natural sub-module: sync_fifo (parametrised width/depth, push/pop/flush, count, full/empty). It is instantiated twice: the prefetch queue (XLEN+32 wide) and the in-flight pc FIFO (XLEN wide, depth MAX_OUTSTANDING).

Test Plan:
- Reset release, memory with zero-wait ar_ready/1-cycle r_valid, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008; insts from low/high/low halves of 64-bit beats.
- out_ready=0 held -> exactly FIFO_DEPTH=4 entries queued, ar_valid stays 0 afterward, no overflow; release out_ready -> entries drain in order, fetch resumes at 0x80000010.
- br_valid with br_pc=0x80001002 while 2 requests outstanding -> the 2 stale beats are discarded, next out_pc=0x80001000, queue empty the cycle after the redirect.
- trap_valid (trap_pc=0x80000100) and br_valid (0x80002000) in the same cycle, with ar_valid held by ar_ready=0 -> the held request is dropped on acceptance, next fetch at 0x80000100.
- Response r_valid in the same cycle as a redirect -> beat not delivered; drop_cnt accounting returns to 0; no spurious out_valid.
- rst asserted mid-stream with 2 outstanding -> all outputs at reset values the next cycle, fetch restarts at 0x80000000.
